// File: rtl/hyperbus_mux_arbiter.sv
// Two-requester arbiter for a shared HyperBus PHY path behind a 2:1 select mux.
// Latency: grant 1 cycle after an IDLE request (1+GUARD_CYCLES on a select change).
// Backpressure: requests wait in IDLE; a grant holds until done or timeout.
module hyperbus_mux_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  input  logic       trans_done_i,
  output logic       sel_o,
  output logic       phy_en_o,
  output logic       owner_o,
  output logic       abort_o,
  output logic       timeout_o,
  input  logic       clr_timeout_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Last BUSY count value before a forced release; unused when the timeout is off.
  localparam int unsigned TO_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIM);
  localparam logic [CNT_W-1:0] GUARD_INIT = CNT_W'(GUARD_CYCLES);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             phy_en_q, phy_en_d;
  logic             owner_q, owner_d;
  logic             abort_q, abort_d;
  logic             timeout_q, timeout_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] guard_q, guard_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             winner;
  logic             set_timeout;

  // Round-robin winner: a lone request wins outright, a tie goes to whoever was not served last.
  always_comb begin
    winner = 1'b0;
    if (req_i == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = req_i[1];
    end
  end

  // Next-state and registered-output decode for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    phy_en_d    = phy_en_q;
    owner_d     = owner_q;
    abort_d     = 1'b0;
    last_d      = last_q;
    guard_d     = guard_q;
    tmo_d       = tmo_q;
    set_timeout = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          owner_d = winner;
          sel_d   = winner;
          if ((winner == sel_q) || (GUARD_CYCLES == 0)) begin
            // Mux already points at the winner (or no settle needed): grant now.
            state_d  = BUSY;
            gnt_d    = winner ? 2'b10 : 2'b01;
            phy_en_d = 1'b1;
            tmo_d    = '0;
          end else begin
            state_d = SETTLE;
            guard_d = GUARD_INIT;
          end
        end
      end

      SETTLE: begin
        // Let the mux output settle before the PHY sees the new path.
        if (guard_q <= CNT_W'(1)) begin
          state_d  = BUSY;
          guard_d  = '0;
          gnt_d    = owner_q ? 2'b10 : 2'b01;
          phy_en_d = 1'b1;
          tmo_d    = '0;
        end else begin
          guard_d = guard_q - CNT_W'(1);
        end
      end

      BUSY: begin
        // A completed transaction beats a timeout landing on the same cycle.
        if (trans_done_i) begin
          state_d  = RELEASE;
          gnt_d    = 2'b00;
          phy_en_d = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TO_LAST)) begin
          state_d     = RELEASE;
          gnt_d       = 2'b00;
          phy_en_d    = 1'b0;
          abort_d     = 1'b1;
          set_timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        // Select is left where it is so a repeat owner needs no guard interval.
        last_d  = owner_q;
        state_d = IDLE;
        tmo_d   = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear.
  always_comb begin
    timeout_d = timeout_q;
    if (set_timeout) begin
      timeout_d = 1'b1;
    end else if (clr_timeout_i) begin
      timeout_d = 1'b0;
    end
  end

  // State and output registers; reset drops any grant immediately without an abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      gnt_q     <= 2'b00;
      phy_en_q  <= 1'b0;
      owner_q   <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 1'b1;
      guard_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      phy_en_q  <= phy_en_d;
      owner_q   <= owner_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      guard_q   <= guard_d;
      tmo_q     <= tmo_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign phy_en_o  = phy_en_q;
  assign owner_o   = owner_q;
  assign abort_o   = abort_q;
  assign timeout_o = timeout_q;

endmodule
